// File: rtl/rlbp_code_fifo.sv
// RLBP code FIFO: packs comparator bits into 8-bit LBP codes and buffers them for Wishbone readout.
// Optional level interrupt is built when RLBP_FIFO_IRQ_EN is defined.
module rlbp_code_fifo #(
  parameter int DEPTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        cmp_bit,
  input  logic        cmp_valid,
  input  logic        frame_sync,
  output logic        irq_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] LVL_FULL = (PW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   level;
  logic [2:0]    cnt;
  logic [7:0]    asm_q, asm_nxt;
  logic          en, udf, ovf, served;
  logic [3:0]    thr;
  logic          empty, full;
  logic          req, wr, rd_data, pop, udf_set, ctrl_wr, stat_wr, clr;
  logic          shift, push, push_ok, ovf_set;
  logic [7:0]    off;
  logic [31:0]   rdata;

  assign empty = (level == '0);
  assign full  = (level == LVL_FULL);

  // served blocks re-triggering while the master keeps the strobe asserted
  assign off     = wbs_adr_i[7:0];
  assign req     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:28] == 4'h3) & ~wbs_ack_o & ~served;
  assign wr      = req & wbs_we_i & wbs_sel_i[0];
  assign rd_data = req & ~wbs_we_i & (off == 8'h40);
  assign pop     = rd_data & ~empty;
  assign udf_set = rd_data & empty;
  assign ctrl_wr = wr & (off == 8'h48);
  assign stat_wr = wr & (off == 8'h44);
  assign clr     = ctrl_wr & wbs_dat_i[1];

  assign asm_nxt = MSB_FIRST ? {asm_q[6:0], cmp_bit} : {cmp_bit, asm_q[7:1]};
  assign shift   = en & cmp_valid & ~frame_sync;
  assign push    = shift & (cnt == 3'd7) & ~clr;
  // a simultaneous pop frees the slot, so a full FIFO can still accept
  assign push_ok = push & (~full | pop);
  assign ovf_set = push & ~push_ok;

  always_comb begin
    rdata = '0;
    case (off)
      8'h40: rdata = {23'b0, empty, empty ? 8'h00 : mem[rd_ptr]};
      8'h44: rdata = {16'b0, 8'(level), 4'b0, udf, ovf, full, empty};
      8'h48: rdata = {20'b0, thr, 6'b0, 1'b0, en};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i)
    if (push_ok && !wb_rst_i) mem[wr_ptr] <= asm_nxt;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      served    <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      cnt       <= '0;
      asm_q     <= '0;
      en        <= 1'b0;
      udf       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= (req && !wbs_we_i) ? rdata : 32'h0;
      served    <= wbs_cyc_i & wbs_stb_i & (served | req);
      if (ctrl_wr) en <= wbs_dat_i[0];
      if (shift) asm_q <= asm_nxt;
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
        cnt    <= '0;
        udf    <= 1'b0;
        ovf    <= 1'b0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        level <= level + (PW+1)'(push_ok) - (PW+1)'(pop);
        if (frame_sync) cnt <= '0;
        else if (shift) cnt <= cnt + 3'd1;
        udf <= (udf & ~(stat_wr & wbs_dat_i[3])) | udf_set;
        ovf <= (ovf & ~(stat_wr & wbs_dat_i[2])) | ovf_set;
      end
    end
  end

`ifdef RLBP_FIFO_IRQ_EN
  logic irq_q;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      thr   <= '0;
      irq_q <= 1'b0;
    end else begin
      if (ctrl_wr) thr <= wbs_dat_i[11:8];
      irq_q <= en & (5'(level) >= {1'b0, thr}) & (thr != 4'd0);
    end
  end
  assign irq_o = irq_q;
`else
  assign thr   = 4'd0;
  assign irq_o = 1'b0;
`endif

  logic unused;
  assign unused = ^{wbs_dat_i[31:4], wbs_adr_i[27:8], wbs_sel_i[3:1]};
endmodule

// File: tb/tb_rlbp_code_fifo.sv
// Directed bench for rlbp_code_fifo: vector table for register/code traffic plus corner-case sequences.
module tb_rlbp_code_fifo;
  logic        clk = 1'b0, rst = 1'b1;
  logic        stb = 0, cyc = 0, we = 0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] adr = 0, wdat = 0;
  logic        ack;
  logic [31:0] rdat;
  logic        cbit = 0, cvalid = 0, fsync = 0;
  logic        irq;

  int checks = 0, errors = 0;
  localparam logic [31:0] B = 32'h3000_0000;
`ifdef RLBP_FIFO_IRQ_EN
  localparam logic [31:0] CTRL_F01 = 32'h0000_0F01;
`else
  localparam logic [31:0] CTRL_F01 = 32'h0000_0001;
`endif

  rlbp_code_fifo dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .cmp_bit(cbit), .cmp_valid(cvalid), .frame_sync(fsync), .irq_o(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;   // 0 read+check, 1 write, 2 push code
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, output logic [31:0] r);
    int n;
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = a; wdat = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!ack && n < 10);
    if (!ack) begin
      checks++; errors++;
      $display("FAIL ack_timeout adr=%h", a);
    end
    r = rdat;
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    xfer(1'b0, a, 32'h0, r);
    chk(name, r, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    xfer(1'b1, a, d, r);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk); cvalid = 1; cbit = b;
    @(negedge clk); cvalid = 0;
  endtask

  task automatic send_code(input logic [7:0] c);
    for (int i = 7; i >= 0; i--) send_bit(c[i]);
  endtask

  initial begin
    logic [31:0] r;
    int nack;

    tv.push_back('{2'd0, B | 32'h44, 32'h0, 32'h1});
    tv.push_back('{2'd0, B | 32'h40, 32'h0, 32'h100});
    tv.push_back('{2'd0, B | 32'h44, 32'h0, 32'h9});
    tv.push_back('{2'd1, B | 32'h44, 32'h8, 32'h0});
    tv.push_back('{2'd0, B | 32'h44, 32'h0, 32'h1});
    tv.push_back('{2'd1, B | 32'h48, 32'h1, 32'h0});
    tv.push_back('{2'd0, B | 32'h48, 32'h0, 32'h1});
    tv.push_back('{2'd2, 32'h0, 32'hB2, 32'h0});
    tv.push_back('{2'd0, B | 32'h44, 32'h0, 32'h100});
    tv.push_back('{2'd0, B | 32'h40, 32'h0, 32'hB2});
    tv.push_back('{2'd0, B | 32'h44, 32'h0, 32'h1});
    tv.push_back('{2'd0, B | 32'h50, 32'h0, 32'h0});
    tv.push_back('{2'd1, B | 32'h48, 32'hF01, 32'h0});
    tv.push_back('{2'd0, B | 32'h48, 32'h0, CTRL_F01});
    tv.push_back('{2'd1, B | 32'h48, 32'h1, 32'h0});
    // clr empties a non-empty FIFO; en survives, clr reads back 0
    tv.push_back('{2'd2, 32'h0, 32'hA5, 32'h0});
    tv.push_back('{2'd1, B | 32'h48, 32'h3, 32'h0});
    tv.push_back('{2'd0, B | 32'h44, 32'h0, 32'h1});
    tv.push_back('{2'd0, B | 32'h48, 32'h0, 32'h1});

    repeat (3) @(negedge clk);
    chk("rst_ack", {31'b0, ack}, 32'h0);
    chk("rst_dat", rdat, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    rst = 0;

    foreach (tv[i]) begin
      case (tv[i].op)
        2'd0: rd_chk($sformatf("vec%0d", i), tv[i].adr, tv[i].exp);
        2'd1: wr(tv[i].adr, tv[i].wd);
        default: send_code(tv[i].wd[7:0]);
      endcase
    end

    // partial code discarded by frame_sync
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    @(negedge clk); fsync = 1;
    @(negedge clk); fsync = 0;
    send_code(8'hFF);
    rd_chk("fs_status", B | 32'h44, 32'h100);
    rd_chk("fs_data", B | 32'h40, 32'hFF);
    rd_chk("fs_empty", B | 32'h44, 32'h1);

    // overflow: DEPTH+1 pushes
    for (int i = 0; i < 9; i++) send_code(8'h10 + 8'(i));
    rd_chk("ovf_status", B | 32'h44, 32'h806);
    for (int i = 0; i < 8; i++) rd_chk($sformatf("ovf_data%0d", i), B | 32'h40, 32'h10 + 32'(i));
    rd_chk("ovf_drained", B | 32'h44, 32'h5);
    wr(B | 32'h44, 32'h4);
    rd_chk("ovf_clear", B | 32'h44, 32'h1);

    // held strobe: one ack, one pop
    send_code(8'h21);
    send_code(8'h22);
    @(negedge clk); cyc = 1; stb = 1; we = 0; adr = B | 32'h40;
    nack = 0; r = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack) begin nack++; r = rdat; end
    end
    cyc = 0; stb = 0;
    chk("hold_acks", 32'(nack), 32'h1);
    chk("hold_data", r, 32'h21);
    rd_chk("hold_level", B | 32'h44, 32'h100);
    rd_chk("hold_next", B | 32'h40, 32'h22);

    // pop and code completion in the same cycle
    send_code(8'h31);
    send_code(8'h32);
    for (int i = 7; i >= 1; i--) send_bit(1'(8'h33 >> i));
    @(negedge clk);
    cvalid = 1; cbit = 1'b1; cyc = 1; stb = 1; we = 0; adr = B | 32'h40;
    @(negedge clk);
    cvalid = 0;
    chk("pp_ack", {31'b0, ack}, 32'h1);
    chk("pp_data", rdat, 32'h31);
    cyc = 0; stb = 0;
    rd_chk("pp_level", B | 32'h44, 32'h200);
    rd_chk("pp_d1", B | 32'h40, 32'h32);
    rd_chk("pp_d2", B | 32'h40, 32'h33);

    // irq threshold 3
    wr(B | 32'h48, 32'h301);
    send_code(8'h41);
    send_code(8'h42);
    send_code(8'h43);
`ifdef RLBP_FIFO_IRQ_EN
    chk("irq_lat", {31'b0, irq}, 32'h0);
    @(negedge clk);
    chk("irq_rise", {31'b0, irq}, 32'h1);
    rd_chk("irq_pop", B | 32'h40, 32'h41);
    chk("irq_hold", {31'b0, irq}, 32'h1);
    @(negedge clk);
    chk("irq_fall", {31'b0, irq}, 32'h0);
`else
    @(negedge clk);
    chk("irq_off", {31'b0, irq}, 32'h0);
    rd_chk("irq_pop", B | 32'h40, 32'h41);
`endif
    rd_chk("irq_d2", B | 32'h40, 32'h42);
    rd_chk("irq_d3", B | 32'h40, 32'h43);

    // reset during a request: no ack, state cleared
    send_code(8'h77);
    @(negedge clk); cyc = 1; stb = 1; we = 0; adr = B | 32'h40; rst = 1;
    @(negedge clk);
    chk("rst_req_ack", {31'b0, ack}, 32'h0);
    rst = 0; cyc = 0; stb = 0;
    rd_chk("rst_status", B | 32'h44, 32'h1);
    rd_chk("rst_ctrl", B | 32'h48, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=done");
    $fatal(1);
  end
endmodule
